pll_rst_seq: RTL and testbench



---
 rtl/pll_rst_seq_pkg.sv | 46 ++++
 rtl/pll_rst_seq_sync_2ff.sv | 25 ++
 rtl/pll_rst_seq.sv | 130 +++++++++++++
 tb/tb_pll_rst_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared state encoding and output decode for the PLL/DDR/user reset sequencer.
// The enum values are what the ChipScope ILA sees on STATE_OUT.
package pll_rst_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StDdrRel   = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5
  } state_e;

  typedef struct packed {
    logic pll_rst;
    logic ddr_rst;
    logic user_rst;
    logic ready;
    logic fail;
  } rst_outs_t;

  // Reset levels per state; the release order PLL -> DDR -> user is encoded here.
  function automatic rst_outs_t decode_outs(state_e st);
    rst_outs_t o;
    o = '{pll_rst: 1'b1, ddr_rst: 1'b1, user_rst: 1'b1, ready: 1'b0, fail: 1'b0};
    case (st)
      StWaitLock, StStable: o.pll_rst = 1'b0;
      StDdrRel: begin
        o.pll_rst = 1'b0;
        o.ddr_rst = 1'b0;
      end
      StRun: begin
        o.pll_rst  = 1'b0;
        o.ddr_rst  = 1'b0;
        o.user_rst = 1'b0;
        o.ready    = 1'b1;
      end
      StFail:  o.fail = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// One-bit two-flop synchronizer with synchronous active-high clear.
// Used for LOCKED_IN and other cross-domain status bits.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// Reset sequencer on the free-running board clock: PLL reset, wait for stable lock,
// then release the DDR2 controller reset and finally the user-logic reset.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned DDR_REL_DELAY  = 64,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RETRY_W        = 2
) (
  input  logic               CLKIN1_IN,
  input  logic               RST_IN,
  input  logic               LOCKED_IN,
  output logic               PLL_RST_OUT,
  output logic               DDR_RST_OUT,
  output logic               USER_RST_OUT,
  output logic               READY_OUT,
  output logic               FAIL_OUT,
  output logic [RETRY_W-1:0] RETRY_CNT_OUT,
  output logic [STATE_W-1:0] STATE_OUT
);

  localparam logic [CNT_W-1:0]   PllRstLast = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   StableLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DdrRelLast = CNT_W'(DDR_REL_DELAY - 1);
  localparam logic [RETRY_W-1:0] RetryMax   = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk_i (CLKIN1_IN),
    .rst_i (RST_IN),
    .d_i   (LOCKED_IN),
    .q_o   (lock_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  rst_outs_t          outs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    unique case (state_q)
      StPllRst: begin
        if (cnt_q == PllRstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        // Lock beats a coincident timeout.
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          cnt_d = '0;
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = StPllRst;
          end else begin
            state_d = StFail;
          end
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StDdrRel;
          cnt_d   = '0;
        end
      end
      StDdrRel: begin
        if (!lock_s) begin
          state_d = StPllRst;
          cnt_d   = '0;
        end else if (cnt_q == DdrRelLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = StPllRst;
        end
      end
      StFail: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode next-state so they switch on the same edge as the state register.
  always_ff @(posedge CLKIN1_IN) begin
    if (RST_IN) begin
      state_q <= StPllRst;
      cnt_q   <= '0;
      retry_q <= '0;
      outs_q  <= decode_outs(StPllRst);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      outs_q  <= decode_outs(state_d);
    end
  end

  assign PLL_RST_OUT   = outs_q.pll_rst;
  assign DDR_RST_OUT   = outs_q.ddr_rst;
  assign USER_RST_OUT  = outs_q.user_rst;
  assign READY_OUT     = outs_q.ready;
  assign FAIL_OUT      = outs_q.fail;
  assign RETRY_CNT_OUT = retry_q;
  assign STATE_OUT     = state_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed vector bench for pll_rst_seq with small cycle parameters, plus
// hand-written latency checks and a random-lock ordering soak.
module tb_pll_rst_seq;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       locked_in = 1'b0;
  logic       pll_rst, ddr_rst, user_rst, ready, fail;
  logic [1:0] retry;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  pll_rst_seq #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .DDR_REL_DELAY  (4),
    .MAX_RETRIES    (2),
    .CNT_W          (16),
    .RETRY_W        (2)
  ) dut (
    .CLKIN1_IN     (clk),
    .RST_IN        (rst_in),
    .LOCKED_IN     (locked_in),
    .PLL_RST_OUT   (pll_rst),
    .DDR_RST_OUT   (ddr_rst),
    .USER_RST_OUT  (user_rst),
    .READY_OUT     (ready),
    .FAIL_OUT      (fail),
    .RETRY_CNT_OUT (retry),
    .STATE_OUT     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       locked;
    int         ticks;
    logic [2:0] st;
    logic [4:0] outs;   // {pll, ddr, user, ready, fail}
    logic [1:0] retry;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, logic r, logic l, int t, logic [2:0] s,
                              logic [4:0] o, logic [1:0] rc);
    vec_t v;
    v.name = n; v.rst = r; v.locked = l; v.ticks = t; v.st = s; v.outs = o; v.retry = rc;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    int cnt;
    int bad_prints;

    // Reset-release PLL reset width, measured by counting edges.
    repeat (3) tick();
    check("reset_pll_rst", {29'd0, pll_rst, ddr_rst, user_rst}, 32'd7);
    rst_in = 1'b0;
    cnt = 0;
    while (pll_rst && cnt < 50) begin
      tick();
      cnt++;
    end
    check("pll_rst_width", cnt, 4);

    // 1. Nominal bring-up.
    add("t1_reset",       1, 0,  3, 3'd0, 5'b11100, 2'd0);
    add("t1_pllrst_hold", 0, 0,  3, 3'd0, 5'b11100, 2'd0);
    add("t1_wait_entry",  0, 0,  1, 3'd1, 5'b01100, 2'd0);
    add("t1_wait_10",     0, 0, 10, 3'd1, 5'b01100, 2'd0);
    add("t1_stable_last", 0, 1, 10, 3'd2, 5'b01100, 2'd0);
    add("t1_ddr_rel",     0, 1,  1, 3'd3, 5'b00100, 2'd0);
    add("t1_ddr_hold",    0, 1,  3, 3'd3, 5'b00100, 2'd0);
    add("t1_run",         0, 1,  1, 3'd4, 5'b00010, 2'd0);
    // 4. Lock loss in RUN and replay.
    add("t4_loss_pre",    0, 0,  2, 3'd4, 5'b00010, 2'd0);
    add("t4_loss_edge",   0, 0,  1, 3'd0, 5'b11100, 2'd0);
    add("t4_pllrst",      0, 1,  3, 3'd0, 5'b11100, 2'd0);
    add("t4_wait",        0, 1,  1, 3'd1, 5'b01100, 2'd0);
    add("t4_stable",      0, 1,  1, 3'd2, 5'b01100, 2'd0);
    add("t4_stable_last", 0, 1,  7, 3'd2, 5'b01100, 2'd0);
    add("t4_ddr_rel",     0, 1,  1, 3'd3, 5'b00100, 2'd0);
    add("t4_ddr_hold",    0, 1,  3, 3'd3, 5'b00100, 2'd0);
    add("t4_run",         0, 1,  1, 3'd4, 5'b00010, 2'd0);
    // 2. Lock timeout, retries, FAIL, recovery by reset.
    add("t2_reset",       1, 0,  2, 3'd0, 5'b11100, 2'd0);
    add("t2_pllrst",      0, 0,  3, 3'd0, 5'b11100, 2'd0);
    add("t2_wait0",       0, 0,  1, 3'd1, 5'b01100, 2'd0);
    add("t2_wait0_last",  0, 0, 31, 3'd1, 5'b01100, 2'd0);
    add("t2_retry1",      0, 0,  1, 3'd0, 5'b11100, 2'd1);
    add("t2_retry1_hold", 0, 0,  3, 3'd0, 5'b11100, 2'd1);
    add("t2_wait1",       0, 0,  1, 3'd1, 5'b01100, 2'd1);
    add("t2_wait1_last",  0, 0, 31, 3'd1, 5'b01100, 2'd1);
    add("t2_retry2",      0, 0,  1, 3'd0, 5'b11100, 2'd2);
    add("t2_retry2_hold", 0, 0,  3, 3'd0, 5'b11100, 2'd2);
    add("t2_wait2",       0, 0,  1, 3'd1, 5'b01100, 2'd2);
    add("t2_wait2_last",  0, 0, 31, 3'd1, 5'b01100, 2'd2);
    add("t2_fail",        0, 0,  1, 3'd5, 5'b11101, 2'd2);
    add("t2_fail_sticky", 0, 1, 20, 3'd5, 5'b11101, 2'd2);
    add("t2_fail_reset",  1, 1,  1, 3'd0, 5'b11100, 2'd0);
    // 5. One-cycle reset during DDR_REL.
    add("t5_wait",        0, 1,  4, 3'd1, 5'b01100, 2'd0);
    add("t5_stable",      0, 1,  1, 3'd2, 5'b01100, 2'd0);
    add("t5_ddr_rel",     0, 1,  8, 3'd3, 5'b00100, 2'd0);
    add("t5_ddr_mid",     0, 1,  1, 3'd3, 5'b00100, 2'd0);
    add("t5_reset",       1, 1,  1, 3'd0, 5'b11100, 2'd0);
    add("t5_re_pllrst",   0, 1,  3, 3'd0, 5'b11100, 2'd0);
    add("t5_re_wait",     0, 1,  1, 3'd1, 5'b01100, 2'd0);
    add("t5_re_stable",   0, 1,  1, 3'd2, 5'b01100, 2'd0);
    add("t5_re_ddr_rel",  0, 1,  8, 3'd3, 5'b00100, 2'd0);
    add("t5_re_run",      0, 1,  4, 3'd4, 5'b00010, 2'd0);
    // 3. Two-cycle lock drop at stability count 5.
    add("t3_reset",       1, 1,  1, 3'd0, 5'b11100, 2'd0);
    add("t3_wait",        0, 1,  4, 3'd1, 5'b01100, 2'd0);
    add("t3_stable",      0, 1,  1, 3'd2, 5'b01100, 2'd0);
    add("t3_count5",      0, 1,  5, 3'd2, 5'b01100, 2'd0);
    add("t3_drop",        0, 0,  2, 3'd2, 5'b01100, 2'd0);
    add("t3_back_wait",   0, 1,  1, 3'd1, 5'b01100, 2'd0);
    add("t3_wait_sync",   0, 1,  1, 3'd1, 5'b01100, 2'd0);
    add("t3_restable",    0, 1,  1, 3'd2, 5'b01100, 2'd0);
    add("t3_fresh_last",  0, 1,  7, 3'd2, 5'b01100, 2'd0);
    add("t3_ddr_rel",     0, 1,  1, 3'd3, 5'b00100, 2'd0);
    add("t3_run",         0, 1,  4, 3'd4, 5'b00010, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_in    = vecs[i].rst;
      locked_in = vecs[i].locked;
      repeat (vecs[i].ticks) tick();
      check(vecs[i].name,
            {22'd0, state, pll_rst, ddr_rst, user_rst, ready, fail, retry},
            {22'd0, vecs[i].st, vecs[i].outs, vecs[i].retry});
    end

    // Lock-loss latency from RUN: resets reassert on the third edge.
    locked_in = 1'b0;
    cnt = 0;
    while (ready && cnt < 20) begin
      tick();
      cnt++;
    end
    check("loss_latency", cnt, 3);
    check("loss_all_resets", {29'd0, pll_rst, ddr_rst, user_rst}, 32'd7);

    // Random lock soak with ordering invariants every cycle.
    bad_prints = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 39) == 0) locked_in = ~locked_in;
      rst_in = ($urandom_range(0, 1999) == 0);
      tick();
      n_tests += 4;
      if ((!ddr_rst && pll_rst) || (!user_rst && ddr_rst) ||
          (ready != (state == 3'd4)) || (fail != (state == 3'd5))) begin
        n_fail++;
        if (bad_prints < 10) begin
          bad_prints++;
          $display("FAIL ordering at cycle %0d: got pll=%b ddr=%b user=%b ready=%b fail=%b st=%0d",
                   c, pll_rst, ddr_rst, user_rst, ready, fail, state);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
